// File: rtl/trace_capture_pkg.sv
// Shared types for the commit-trace capture block.
// Frame: {kind,6'b0,idx[8]}, idx[7:0], data bytes MSB first.
package trace_pkg;

  typedef enum logic {
    REG = 1'b0,
    MEM = 1'b1
  } trace_type_e;

  typedef struct packed {
    trace_type_e kind;
    logic [8:0]  idx;
    logic [31:0] data;
  } trace_entry_t;

  localparam int FRAME_BYTES = 6;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  function automatic logic [7:0] frame_byte(
    trace_entry_t e,
    logic [2:0]   n
  );
    logic [7:0] b;
    case (n)
      3'd0:    b = {e.kind, 6'b0, e.idx[8]};
      3'd1:    b = e.idx[7:0];
      3'd2:    b = e.data[31:24];
      3'd3:    b = e.data[23:16];
      3'd4:    b = e.data[15:8];
      3'd5:    b = e.data[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/trace_capture_if.sv
// Byte-wide valid/ready stream carrying trace frames.
interface trace_capture_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/trace_capture_fifo.sv
// Trace entry FIFO: two ordered write ports, one read port.
// Callers only assert writes that fit the free space.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we0,
  input  trace_entry_t           wd0,
  input  logic                   we1,
  input  trace_entry_t           wd1,
  input  logic                   re,
  output trace_entry_t           rd,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  trace_entry_t mem_q [DEPTH];

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW-1:0] wp1;
  logic [LW-1:0] level_q, level_d;

  always_comb begin
    wp1     = wp_q + AW'(1);
    wp_d    = wp_q + AW'(we0) + AW'(we1);
    rp_d    = rp_q + AW'(re);
    level_d = level_q + LW'(we0) + LW'(we1)
            - LW'(re);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
    end
  end

  // Port 1 lands behind port 0 when both write.
  always_ff @(posedge clk) begin
    if (we0) mem_q[wp_q] <= wd0;
    if (we1) mem_q[we0 ? wp1 : wp_q] <= wd1;
  end

  assign rd    = mem_q[rp_q];
  assign level = level_q;

endmodule

// File: rtl/trace_capture.sv
// Commit-trace receiver: qualifies core events, buffers them,
// and serializes each as a 6-byte frame. Never stalls the core.
module trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 32,
  parameter int FILTER_X0 = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear_stat,
  input  logic                   reg_write_sig,
  input  logic [4:0]             reg_num,
  input  logic [DATA_W-1:0]      reg_data,
  input  logic                   wr,
  input  logic [8:0]             addr,
  input  logic [DATA_W-1:0]      wr_data,
  trace_capture_if.master        tx,
  output logic                   overflow,
  output logic [7:0]             drop_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [2:0] LAST = 3'(FRAME_BYTES - 1);

  logic          reg_ev, mem_ev;
  logic          reg_ok, mem_ok;
  logic [LW-1:0] free;
  logic [1:0]    drops;
  logic [8:0]    sum;
  trace_entry_t  reg_e, mem_e, head;

  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;

  ser_state_e    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  trace_entry_t  frame_q, frame_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          pop;
  logic          nonempty;

  // REG has first claim on the free slots.
  always_comb begin
    reg_ev = enable & reg_write_sig
           & ((FILTER_X0 == 0) || (reg_num != 5'd0));
    mem_ev = enable & wr;
    free   = LW'(DEPTH) - fifo_level;
    reg_ok = reg_ev && (free != '0);
    mem_ok = mem_ev && (free > LW'(reg_ok));
    drops  = 2'(reg_ev & ~reg_ok)
           + 2'(mem_ev & ~mem_ok);

    reg_e.kind = REG;
    reg_e.idx  = {4'b0, reg_num};
    reg_e.data = 32'(reg_data);
    mem_e.kind = MEM;
    mem_e.idx  = addr;
    mem_e.data = 32'(wr_data);
  end

  always_comb begin
    overflow_d = (overflow_q & ~clear_stat)
               | (drops != 2'd0);
    sum = {1'b0, clear_stat ? 8'h00 : drop_q}
        + 9'(drops);
    drop_d = sum[8] ? 8'hFF : sum[7:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    nonempty   = fifo_level != '0;
    unique case (state_q)
      IDLE: begin
        if (nonempty) begin
          pop        = 1'b1;
          frame_d    = head;
          cnt_d      = 3'd0;
          state_d    = SEND;
          tx_valid_d = 1'b1;
          tx_data_d  = frame_byte(head, 3'd0);
        end
      end
      SEND: begin
        if (tx.tx_ready) begin
          if (cnt_q != LAST) begin
            cnt_d     = cnt_q + 3'd1;
            tx_data_d = frame_byte(frame_q, cnt_q + 3'd1);
          end else if (nonempty) begin
            pop       = 1'b1;
            frame_d   = head;
            cnt_d     = 3'd0;
            tx_data_d = frame_byte(head, 3'd0);
          end else begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      frame_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .we0   (reg_ok),
    .wd0   (reg_e),
    .we1   (mem_ok),
    .wd1   (mem_e),
    .re    (pop),
    .rd    (head),
    .level (fifo_level)
  );

  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_data  = tx_data_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_trace_capture.sv
// Randomized bench for trace_capture against a frame-queue model,
// plus directed frames with literal byte expectations.
module tb_trace_capture;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear_stat;
  logic        reg_write_sig;
  logic [4:0]  reg_num;
  logic [31:0] reg_data;
  logic        wr;
  logic [8:0]  addr;
  logic [31:0] wr_data;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [4:0]  fifo_level;
  logic        nf_ovf;
  logic [7:0]  nf_cnt;
  logic [4:0]  nf_lvl;

  trace_capture_if tx_m ();
  trace_capture_if tx_n ();

  assign tx_n.tx_ready = 1'b1;

  always #5 clk = ~clk;

  trace_capture #(
    .DEPTH(DEPTH), .DATA_W(32), .FILTER_X0(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .clear_stat(clear_stat),
    .reg_write_sig(reg_write_sig), .reg_num(reg_num),
    .reg_data(reg_data), .wr(wr), .addr(addr),
    .wr_data(wr_data), .tx(tx_m),
    .overflow(overflow), .drop_count(drop_count),
    .fifo_level(fifo_level)
  );

  trace_capture #(
    .DEPTH(DEPTH), .DATA_W(32), .FILTER_X0(0)
  ) u_nf (
    .clk(clk), .reset(reset), .enable(enable),
    .clear_stat(clear_stat),
    .reg_write_sig(reg_write_sig), .reg_num(reg_num),
    .reg_data(reg_data), .wr(wr), .addr(addr),
    .wr_data(wr_data), .tx(tx_n),
    .overflow(nf_ovf), .drop_count(nf_cnt),
    .fifo_level(nf_lvl)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: queue of whole 48-bit frames plus the frame on the wire.
  logic [47:0] mq[$];
  logic [47:0] cur;
  int          pos   = 0;
  bit          busy  = 0;
  bit          m_ovf = 0;
  int          m_cnt = 0;

  logic [7:0]  acc[$];
  logic [7:0]  acc_nf[$];

  task automatic chk(input string nm,
                     input logic [47:0] act,
                     input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [7:0] m_byte();
    return cur[47 - 8*pos -: 8];
  endfunction

  task automatic model_step();
    int lvl;
    int free;
    int drop;
    if (reset) begin
      mq.delete();
      busy  = 0;
      pos   = 0;
      m_ovf = 0;
      m_cnt = 0;
    end else begin
      lvl = mq.size();
      if (busy && tx_m.tx_ready) begin
        if (pos < 5) pos++;
        else busy = 0;
      end
      if (!busy && lvl > 0) begin
        cur  = mq.pop_front();
        pos  = 0;
        busy = 1;
      end
      free = DEPTH - lvl;
      drop = 0;
      if (enable && reg_write_sig && reg_num != 0) begin
        if (free > 0) begin
          mq.push_back({8'h00, 3'b000, reg_num, reg_data});
          free--;
        end else drop++;
      end
      if (enable && wr) begin
        if (free > 0)
          mq.push_back({1'b1, 6'b0, addr, wr_data});
        else drop++;
      end
      if (clear_stat) begin
        m_ovf = drop > 0;
        m_cnt = drop;
      end else begin
        m_ovf = m_ovf | (drop > 0);
        m_cnt = (m_cnt + drop > 255) ? 255 : m_cnt + drop;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!reset && tx_m.tx_valid && tx_m.tx_ready)
      acc.push_back(tx_m.tx_data);
    if (!reset && tx_n.tx_valid)
      acc_nf.push_back(tx_n.tx_data);
    model_step();
    #1;
    chk("tx_valid", 48'(tx_m.tx_valid), 48'(busy));
    if (busy) chk("tx_data", 48'(tx_m.tx_data), 48'(m_byte()));
    chk("fifo_level", 48'(fifo_level), 48'(mq.size()));
    chk("overflow", 48'(overflow), 48'(m_ovf));
    chk("drop_count", 48'(drop_count), 48'(m_cnt));
  end

  task automatic chk_frame(input string nm, input bit nf,
                           input logic [47:0] exp);
    logic [47:0] g;
    int sz;
    g  = '0;
    sz = nf ? acc_nf.size() : acc.size();
    if (sz < 6) begin
      chk({nm, "_len"}, 48'(sz), 48'd6);
    end else begin
      for (int i = 0; i < 6; i++)
        g = {g[39:0], nf ? acc_nf.pop_front() : acc.pop_front()};
      chk(nm, g, exp);
    end
  endtask

  task automatic clr_ev();
    reg_write_sig = 0;
    wr            = 0;
    clear_stat    = 0;
  endtask

  // mode 1: ready high, 2: toggling, 3: random
  task automatic wait_idle(input int mode);
    int k;
    k = 0;
    while ((tx_m.tx_valid || fifo_level != 0) && k < 600) begin
      @(negedge clk);
      case (mode)
        2:       tx_m.tx_ready = ~tx_m.tx_ready;
        3:       tx_m.tx_ready = 1'($urandom_range(0, 1));
        default: tx_m.tx_ready = 1'b1;
      endcase
      k++;
    end
    if (k >= 600) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d cycles limit 600", k);
    end
    @(negedge clk);
  endtask

  initial begin
    int k;
    int seg;
    reset = 1; enable = 1; clear_stat = 0;
    reg_write_sig = 0; reg_num = 0; reg_data = 0;
    wr = 0; addr = 0; wr_data = 0;
    tx_m.tx_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 48'(tx_m.tx_valid), 48'd0);
    chk("rst_data", 48'(tx_m.tx_data), 48'd0);
    chk("rst_level", 48'(fifo_level), 48'd0);
    chk("rst_ovf", 48'(overflow), 48'd0);
    chk("rst_drops", 48'(drop_count), 48'd0);
    reset = 0;
    tx_m.tx_ready = 1;
    acc.delete();

    // single REG frame and its latency
    @(negedge clk);
    reg_write_sig = 1; reg_num = 5; reg_data = 32'hDEADBEEF;
    @(negedge clk);
    clr_ev();
    chk("lat_level_n1", 48'(fifo_level), 48'd1);
    chk("lat_valid_n1", 48'(tx_m.tx_valid), 48'd0);
    @(negedge clk);
    chk("lat_valid_n2", 48'(tx_m.tx_valid), 48'd1);
    chk("lat_byte0", 48'(tx_m.tx_data), 48'd0);
    wait_idle(1);
    chk_frame("frame_reg5", 0, 48'h0005_DEADBEEF);

    // simultaneous REG + MEM, back to back
    @(negedge clk);
    reg_write_sig = 1; reg_num = 3; reg_data = 32'h11;
    wr = 1; addr = 9'h1A4; wr_data = 32'h22;
    @(negedge clk);
    clr_ev();
    wait_idle(1);
    chk_frame("pair_reg", 0, 48'h0003_00000011);
    chk_frame("pair_mem", 0, 48'h81A4_00000022);

    // x0 write: filtered by dut, framed by u_nf
    acc_nf.delete();
    @(negedge clk);
    reg_write_sig = 1; reg_num = 0; reg_data = 32'hCAFEF00D;
    @(negedge clk);
    clr_ev();
    chk("x0_level", 48'(fifo_level), 48'd0);
    repeat (10) @(negedge clk);
    chk("x0_noframe", 48'(acc.size()), 48'd0);
    chk_frame("nofilter_x0", 1, 48'h0000_CAFEF00D);

    // stall, overfill, clear stats
    tx_m.tx_ready = 0;
    @(negedge clk);
    for (int i = 1; i <= 19; i++) begin
      reg_write_sig = 1;
      reg_num  = 5'(i);
      reg_data = 32'h1000_0000 + 32'(i);
      @(negedge clk);
    end
    clr_ev();
    chk("full_level", 48'(fifo_level), 48'd16);
    chk("full_drops", 48'(drop_count), 48'd2);
    chk("full_ovf", 48'(overflow), 48'd1);
    chk("stall_hold_b0", 48'(tx_m.tx_data), 48'h00);
    clear_stat = 1;
    @(negedge clk);
    clear_stat = 0;
    chk("clr_ovf", 48'(overflow), 48'd0);
    chk("clr_drops", 48'(drop_count), 48'd0);

    // drain with toggling ready
    acc.delete();
    wait_idle(2);
    chk_frame("toggle_f1", 0, 48'h0001_10000001);
    chk_frame("toggle_f2", 0, 48'h0002_10000002);
    acc.delete();

    // reset in the middle of a frame
    tx_m.tx_ready = 1;
    @(negedge clk);
    reg_write_sig = 1; reg_num = 7; reg_data = 32'h01020304;
    wr = 1; addr = 9'h010; wr_data = 32'h55;
    @(negedge clk);
    clr_ev();
    k = 0;
    while (acc.size() < 3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("pre_rst_byte3", 48'(tx_m.tx_data), 48'h02);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("midrst_valid", 48'(tx_m.tx_valid), 48'd0);
    chk("midrst_level", 48'(fifo_level), 48'd0);
    acc.delete();
    reg_write_sig = 1; reg_num = 9; reg_data = 32'hA5A5A5A5;
    @(negedge clk);
    clr_ev();
    wait_idle(1);
    chk_frame("after_rst", 0, 48'h0009_A5A5A5A5);
    chk("after_rst_only", 48'(acc.size()), 48'd0);

    // randomized traffic in phases
    for (int c = 0; c < 3600; c++) begin
      seg = (c / 300) % 4;
      enable = $urandom_range(0, 9) != 0;
      reg_num  = ($urandom_range(0, 3) == 0) ?
                 5'd0 : 5'($urandom);
      reg_data = $urandom;
      addr     = 9'($urandom);
      wr_data  = $urandom;
      if (seg == 1) begin
        reg_write_sig = $urandom_range(0, 9) != 0;
        wr            = $urandom_range(0, 9) != 0;
      end else begin
        reg_write_sig = 1'($urandom_range(0, 1));
        wr            = $urandom_range(0, 2) == 0;
      end
      case (seg)
        0:       tx_m.tx_ready = 1'($urandom_range(0, 1));
        1:       tx_m.tx_ready = 1'b0;
        2:       tx_m.tx_ready = 1'b1;
        default: tx_m.tx_ready = $urandom_range(0, 9) != 0;
      endcase
      clear_stat = (seg == 0 || seg == 3) &&
                   $urandom_range(0, 40) == 0;
      reset = (seg == 0) && $urandom_range(0, 400) == 0;
      @(negedge clk);
    end
    reset = 0;
    clr_ev();
    wait_idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
